// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage types and constants: bus widths, fetch FSM states, and
// the (pc, instr) entry carried through the fetch queue.
package mips_fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef enum logic {
        FS_BOOT,
        FS_RUN
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched (pc, instr) pairs. Pointers carry an extra wrap
// bit so that full and empty are distinguishable from count alone.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wr_entry,
    output fetch_entry_t           rd_entry,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW:0]   head;
    logic [PW:0]   tail;
    logic          do_push;
    logic          do_pop;

    assign count    = tail - head;
    assign do_pop   = pop && (count != '0);
    assign do_push  = push && (count != (PW+1)'(DEPTH));
    assign rd_entry = mem[head[PW-1:0]];

    // Flush wins over push/pop; the head slot keeps its old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            tail <= head;
        end else begin
            if (do_push) begin
                mem[tail[PW-1:0]] <= wr_entry;
                tail              <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one-word reads to the
// synchronous instruction memory, and queues returned words for decode.
module instr_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    input  logic                   stop,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_pc_plus4,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic [CW:0]        pending;
    logic               room;
    logic               push;
    fetch_entry_t       wr_entry;
    fetch_entry_t       head_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FS_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FS_BOOT: state_next = FS_RUN;
            FS_RUN:  state_next = FS_RUN;
            default: state_next = FS_BOOT;
        endcase
    end

    // Queued plus in-flight words bound the request so a response always has a slot.
    assign pending = {1'b0, occupancy} + {{CW{1'b0}}, inflight};
    assign room    = pending < (CW+1)'(DEPTH);

    always_comb begin
        imem_req = 1'b0;
        if (state == FS_RUN) begin
            imem_req = !stop && !redirect_valid && room;
        end
    end

    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~32'h0000_0003;
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= fetch_pc;
            end
        end
    end

    // A redirect in the response cycle discards the returning word.
    assign push           = inflight && !redirect_valid;
    assign wr_entry.pc    = inflight_pc;
    assign wr_entry.instr = imem_rdata;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (out_ready),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .rd_entry (head_entry),
        .count    (occupancy)
    );

    assign out_valid    = occupancy != '0;
    assign out_instr    = head_entry.instr;
    assign out_pc       = head_entry.pc;
    assign out_pc_plus4 = head_entry.pc + PC_STEP;

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage feeding the CPU's decode/control stage: owns the fetch PC, issues word reads to the synchronous instruction memory, buffers returned instructions with their PCs in a small FIFO, and presents them to decode over a valid/ready handshake. Branch/jump/jr resolution in the execute stage redirects it through a flush port. Sits between instruction memory and decode.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  read request this cycle
- imem_addr  out  32  byte address of request, bits [1:0] always 0
- imem_rdata  in  32  instruction, valid exactly one cycle after the accepted imem_req
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- stop  in  1  end-of-execution: no new requests while high
- out_valid  out  1  out_instr/out_pc valid
- out_ready  in  1  decode accepts head entry
- out_instr  out  32  head instruction
- out_pc  out  32  head instruction address
- out_pc_plus4  out  32  out_pc + 4, modulo 2^32
- occupancy  out  $clog2(DEPTH)+1  entries currently queued

## Operation
- FSM: BOOT → RUN. BOOT lasts exactly one cycle after rst_n deasserts; no request issued. RUN is permanent until reset.
- Request rule (RUN): imem_req = !stop && !redirect_valid && (occupancy + inflight < DEPTH); imem_addr = fetch_pc. On request fetch_pc ← fetch_pc + 4 (wraps 32'hFFFF_FFFC → 0); inflight ← 1 with tag pc.
- Response: cycle after request, {pc_tag, imem_rdata} enqueued unless a redirect occurred in the request's response cycle or earlier since issue (dropped).
- Dequeue: out_valid && out_ready pops head. out_valid = occupancy != 0.
- Redirect (cycle N): handshake in cycle N still completes normally; at end of N queue emptied, in-flight response dropped, fetch_pc ← {redirect_pc[31:2],2'b00}. Redirect overrides stop only for fetch_pc update; stop still blocks requests.
- Simultaneous enqueue + dequeue: occupancy unchanged. Full queue: no request; never overflows. Empty: out_valid 0, out_* hold last value (don't care for verification).
- Redirect during BOOT: fetch_pc updated; BOOT still lasts its cycle.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, out_valid 0, out_instr 0, out_pc 0, out_pc_plus4 4, occupancy 0, fetch_pc RESET_PC, inflight 0.
- Cold start: reset release edge = cycle 0 (BOOT); first request cycle 1; data cycle 2; out_valid cycle 3.
- Redirect latency: redirect cycle N → request to redirect_pc cycle N+1 → out_valid N+3.
- Throughput: one instruction/cycle sustained with out_ready held 1.
- No combinational path from out_ready or redirect_valid to out_valid/out_instr; imem_req depends combinationally on redirect_valid and stop only.

## Structure
- Shared package mips_fetch_pkg: INSTR_W=32, ADDR_W=32, fetch FSM enum {FS_BOOT, FS_RUN}, PC_STEP=4.
- Sub-module fetch_fifo: DEPTH×64-bit circular buffer (pc, instr), head/tail pointers with extra wrap bit, push/pop/flush, count output. Top holds FSM, fetch_pc, in-flight tag, request logic.

## Test plan
- Reset, memory word i = 32'h1000_0000+i, out_ready=1 → out_valid first in cycle 3, out_pc 0,4,8,… one per cycle, out_instr matches.
- out_ready=0 for 10 cycles → occupancy saturates at 4, imem_req drops to 0, no lost/duplicated entries after release.
- Redirect to 32'h0000_0103 while queue has 3 entries and one in flight → occupancy 0 next cycle, next out_pc 32'h0000_0100 at N+3, stale data never appears.
- Redirect same cycle as handshake on pc 0x10 → 0x10 consumed once; next output is redirect target.
- Redirect to 32'hFFFF_FFF8 → out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc_plus4 of FFFF_FFFC is 0.
- stop asserted mid-stream → no further imem_req, queued entries drain; rst_n pulsed low mid-stream → outputs return to reset values immediately (asynchronous).
